// File: rtl/bsg_fifo_gray_wptr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO: owns the binary write pointer,
// publishes a registered gray copy, and derives occupancy/full/error from the synced read pointer.

module bsg_gray_to_binary #(
    parameter int unsigned width_p = 4
) (
    input  logic [width_p-1:0] gray_i,
    output logic [width_p-1:0] binary_o
);

    // Each binary bit is the XOR of all gray bits at or above its position.
    always_comb begin
        binary_o = '0;
        for (int i = 0; i < int'(width_p); i++) begin
            binary_o[i] = ^(gray_i >> i);
        end
    end

endmodule

module bsg_fifo_gray_wptr_ctrl #(
    parameter int unsigned lg_size_p    = 3,
    parameter bit          err_sticky_p = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 clear_i,
    input  logic                 v_i,
    output logic                 ready_o,
    output logic                 w_v_o,
    output logic [lg_size_p-1:0] w_addr_o,
    output logic [lg_size_p:0]   wptr_gray_o,
    input  logic [lg_size_p:0]   rptr_gray_i,
    output logic [lg_size_p:0]   count_o,
    output logic                 full_o,
    output logic                 err_o
);

    localparam int unsigned ptr_w   = lg_size_p + 1;
    localparam int unsigned depth_lp = 1 << lg_size_p;

    logic [ptr_w-1:0] wptr_bin_r;
    logic [ptr_w-1:0] wptr_gray_r;
    logic [ptr_w-1:0] wptr_bin_n;
    logic [ptr_w-1:0] rptr_bin;
    logic [ptr_w-1:0] count;
    logic             err_r;
    logic             err_cond;
    logic             err_n;

    bsg_gray_to_binary #(
        .width_p (ptr_w)
    ) u_rptr_g2b (
        .gray_i   (rptr_gray_i),
        .binary_o (rptr_bin)
    );

    // Occupancy relies on the extra wrap bit; anything above depth means the read side overran.
    assign count    = wptr_bin_r - rptr_bin;
    assign full_o   = (count == ptr_w'(depth_lp));
    assign err_cond = (count > ptr_w'(depth_lp));
    assign count_o  = count;

    assign ready_o    = reset_n_i & ~full_o & ~err_cond;
    assign w_v_o      = v_i & ready_o & ~clear_i;
    assign w_addr_o   = wptr_bin_r[lg_size_p-1:0];
    assign wptr_bin_n = wptr_bin_r + ptr_w'(1);

    assign err_n = err_sticky_p ? (err_r | err_cond) : err_cond;

    // Pointer and error state; clear overrides any concurrent enqueue.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_bin_r  <= '0;
            wptr_gray_r <= '0;
            err_r       <= 1'b0;
        end else if (clear_i) begin
            wptr_bin_r  <= '0;
            wptr_gray_r <= '0;
            err_r       <= 1'b0;
        end else begin
            if (w_v_o) begin
                wptr_bin_r  <= wptr_bin_n;
                wptr_gray_r <= wptr_bin_n ^ (wptr_bin_n >> 1);
            end
            err_r <= err_n;
        end
    end

    assign wptr_gray_o = wptr_gray_r;
    assign err_o       = err_r;

endmodule
